// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-port memory between instruction fetch and
// the data load/store path. Each access holds MEM_EN for WAIT_CYCLES cycles,
// then spends one RESP cycle pulsing the owner's ACK.
//
// Handshake: a requester raises REQ with address/data stable and holds it until
// its ACK pulse. The request is accepted at the rising edge that finds the FSM
// in IDLE; later changes to REQ, address or data do not affect that access.
// A REQ still high when the FSM is back in IDLE is a new request.
module memory_arbiter #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 16,
    parameter int WAIT_CYCLES    = 2,
    parameter int MAX_DATA_BURST = 3
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              IF_REQ,
    input  logic [ADDR_W-1:0] IF_ADDR,
    output logic              IF_ACK,
    output logic [DATA_W-1:0] IF_RDATA,
    input  logic              D_REQ,
    input  logic              D_WE,
    input  logic [ADDR_W-1:0] D_ADDR,
    input  logic [DATA_W-1:0] D_WDATA,
    output logic              D_ACK,
    output logic [DATA_W-1:0] D_RDATA,
    output logic              MEM_EN,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA,
    output logic              BUSY
);

    localparam int CNT_W   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int BURST_W = $clog2(MAX_DATA_BURST + 1);

    localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_DATA_BURST);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic               owner_q, owner_d;   // 1 = data requester owns the access
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]  d_rdata_q, d_rdata_d;
    logic               grant_data;

    // Next-state logic: arbitration in IDLE, wait-state countdown in ACCESS.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        burst_d    = burst_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        grant_data = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (IF_REQ || D_REQ) begin
                    // Data wins unless fetch is waiting and data has used its burst.
                    grant_data = D_REQ && (!IF_REQ || (burst_q < BURST_MAX));
                    if (grant_data) begin
                        owner_d = 1'b1;
                        we_d    = D_WE;
                        addr_d  = D_ADDR;
                        wdata_d = D_WDATA;
                        if (burst_q < BURST_MAX) begin
                            burst_d = burst_q + BURST_W'(1);
                        end
                    end else begin
                        owner_d = 1'b0;
                        we_d    = 1'b0;
                        addr_d  = IF_ADDR;
                        wdata_d = '0;
                        burst_d = '0;
                    end
                    cnt_d   = CNT_LOAD;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        if (owner_q) begin
                            d_rdata_d = MEM_RDATA;
                        end else begin
                            if_rdata_d = MEM_RDATA;
                        end
                    end
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any access in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            burst_q    <= '0;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            burst_q    <= burst_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // Outputs decode registered state only, so no REQ-to-output path exists.
    always_comb begin
        MEM_EN    = (state_q == ST_ACCESS);
        MEM_WE    = (state_q == ST_ACCESS) && owner_q && we_q;
        MEM_ADDR  = addr_q;
        MEM_WDATA = wdata_q;
        IF_ACK    = (state_q == ST_RESP) && !owner_q;
        D_ACK     = (state_q == ST_RESP) && owner_q;
        IF_RDATA  = if_rdata_q;
        D_RDATA   = d_rdata_q;
        BUSY      = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed table of single accesses, hand-written
// reset/contention/abort sequences, a randomized run against a transaction
// model, and a second instance built with WAIT_CYCLES=1.
module tb_memory_arbiter;

  localparam int W    = 2;
  localparam int MAXB = 3;

  logic        clk;
  logic        rst_n;
  logic        if_req, d_req, d_we;
  logic [15:0] if_addr, d_addr, d_wdata;
  logic        if_ack, d_ack, mem_en, mem_we, busy;
  logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        if_req1;
  logic        if_ack1, d_ack1, mem_en1, mem_we1, busy1;
  logic [15:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1;

  int n_vec = 0;
  int n_err = 0;

  memory_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(W), .MAX_DATA_BURST(MAXB)) dut (
    .CLK(clk), .RST_N(rst_n),
    .IF_REQ(if_req), .IF_ADDR(if_addr), .IF_ACK(if_ack), .IF_RDATA(if_rdata),
    .D_REQ(d_req), .D_WE(d_we), .D_ADDR(d_addr), .D_WDATA(d_wdata),
    .D_ACK(d_ack), .D_RDATA(d_rdata),
    .MEM_EN(mem_en), .MEM_WE(mem_we), .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata),
    .MEM_RDATA(mem_rdata), .BUSY(busy)
  );

  memory_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(1), .MAX_DATA_BURST(MAXB)) dut_w1 (
    .CLK(clk), .RST_N(rst_n),
    .IF_REQ(if_req1), .IF_ADDR(16'h0007), .IF_ACK(if_ack1), .IF_RDATA(if_rdata1),
    .D_REQ(1'b0), .D_WE(1'b0), .D_ADDR(16'h0000), .D_WDATA(16'h0000),
    .D_ACK(d_ack1), .D_RDATA(d_rdata1),
    .MEM_EN(mem_en1), .MEM_WE(mem_we1), .MEM_ADDR(mem_addr1), .MEM_WDATA(mem_wdata1),
    .MEM_RDATA(16'hC0DE), .BUSY(busy1)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory macro model ----------------
  function automatic logic [15:0] init_val(input int a);
    return 16'(a * 40503) ^ 16'h5A5A;
  endfunction

  logic [15:0] mem [0:1023];
  bit          mem_ok [0:1023];
  logic        pre_we;
  logic [15:0] pre_addr, pre_data;

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_addr[9:0]]    <= pre_data;
      mem_ok[pre_addr[9:0]] <= 1'b1;
    end else if (mem_en && mem_we) begin
      mem[mem_addr[9:0]]    <= mem_wdata;
      mem_ok[mem_addr[9:0]] <= 1'b1;
    end
  end

  assign mem_rdata = mem_ok[mem_addr[9:0]] ? mem[mem_addr[9:0]] : init_val(int'(mem_addr[9:0]));

  // ---------------- compare helpers ----------------
  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [15:0] a, input logic [15:0] v);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = v;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  typedef struct {
    bit          is_d;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    bit          do_pre;
    logic [15:0] pre;
    logic [15:0] exp_rd;
  } vec_t;

  logic [15:0] exp_if_rd, exp_d_rd;

  // One isolated access from IDLE; called at a negedge, returns at a negedge.
  task automatic run_single(input vec_t v);
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      chk1("access_en", mem_en, 1'b1);
      chk1("access_we", mem_we, v.is_d && v.we);
      chk16("access_addr", mem_addr, v.addr);
      if (v.is_d && v.we) chk16("access_wdata", mem_wdata, v.wdata);
      chk2("access_ack", {if_ack, d_ack}, 2'b00);
      chk1("access_busy", busy, 1'b1);
      if (v.is_d) d_addr = ~v.addr; else if_addr = ~v.addr;
    end
    @(negedge clk);
    chk1("resp_en", mem_en, 1'b0);
    chk1("resp_we", mem_we, 1'b0);
    chk2("resp_ack", {if_ack, d_ack}, v.is_d ? 2'b01 : 2'b10);
    if (v.is_d) exp_d_rd = v.exp_rd; else exp_if_rd = v.exp_rd;
    chk16("resp_if_rdata", if_rdata, exp_if_rd);
    chk16("resp_d_rdata", d_rdata, exp_d_rd);
    if_req = 1'b0;
    d_req  = 1'b0;
    @(negedge clk);
    chk2("idle_ack", {if_ack, d_ack}, 2'b00);
    chk1("idle_busy", busy, 1'b0);
  endtask

  // ---------------- random-phase reference model ----------------
  logic [15:0] ref_mem [int];
  int          next_idle, grant_c, ack_c, m_burst;
  bit          acc_valid, own_d, own_we;
  logic [15:0] own_addr, own_wdata, own_exp;
  bit          if_act, if_gnt, d_act, d_gnt;

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    int k;
    k = int'(a[9:0]);
    return ref_mem.exists(k) ? ref_mem[k] : init_val(k);
  endfunction

  function automatic logic [15:0] rnd_addr();
    return 16'h0100 + 16'($urandom_range(0, 31));
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    vec_t tbl [7];
    bit   got_d [8];
    int   grants;
    bit   e_ack, e_en, e_busy, gd;

    tbl[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'hABCD, 16'hABCD};
    tbl[1] = '{1'b1, 1'b0, 16'h0200, 16'h0000, 1'b1, 16'h5555, 16'h5555};
    tbl[2] = '{1'b1, 1'b1, 16'h0200, 16'h1234, 1'b0, 16'h0000, 16'h5555};
    tbl[3] = '{1'b1, 1'b0, 16'h0200, 16'h0000, 1'b0, 16'h0000, 16'h1234};
    tbl[4] = '{1'b0, 1'b0, 16'h0200, 16'h0000, 1'b0, 16'h0000, 16'h1234};
    tbl[5] = '{1'b0, 1'b0, 16'h03FF, 16'h0000, 1'b1, 16'hFFFF, 16'hFFFF};
    tbl[6] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0001, 16'h0001};

    // Reset held with both requests high.
    rst_n = 1'b0; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    if_addr = 16'h0040; d_addr = 16'h0041; d_wdata = 16'h0000;
    if_req1 = 1'b0; pre_we = 1'b0; pre_addr = 16'h0; pre_data = 16'h0;
    repeat (2) @(negedge clk);
    chk1("rst_mem_en", mem_en, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk16("rst_mem_addr", mem_addr, 16'h0000);
    chk16("rst_mem_wdata", mem_wdata, 16'h0000);
    chk2("rst_ack", {if_ack, d_ack}, 2'b00);
    chk16("rst_if_rdata", if_rdata, 16'h0000);
    chk16("rst_d_rdata", d_rdata, 16'h0000);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_busy_w1", busy1, 1'b0);

    // Contention straight out of reset: D,D,D,F,D,D,D,F.
    rst_n  = 1'b1;
    grants = 0;
    for (int c = 0; c < 60 && grants < 8; c++) begin
      @(negedge clk);
      chk1("ack_overlap", if_ack && d_ack, 1'b0);
      if (c == 0) begin
        chk1("first_grant_en", mem_en, 1'b1);
        chk16("first_grant_addr", mem_addr, 16'h0041);
      end
      if (if_ack || d_ack) begin
        got_d[grants] = d_ack;
        grants++;
      end
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    chk1("contention_grants", grants == 8, 1'b1);
    for (int i = 0; i < 8; i++) chk1($sformatf("grant_%0d_is_data", i), got_d[i], (i % 4) != 3);
    @(negedge clk);
    exp_if_rd = init_val(16'h40);
    exp_d_rd  = init_val(16'h41);
    chk16("contention_if_rdata", if_rdata, exp_if_rd);
    chk16("contention_d_rdata", d_rdata, exp_d_rd);

    // Directed single accesses.
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].do_pre) preload(tbl[i].addr, tbl[i].pre);
      run_single(tbl[i]);
    end

    // Reset in the second ACCESS cycle of a fetch, then full replay.
    if_req = 1'b1; if_addr = 16'h0010;
    @(negedge clk);
    chk1("abort_acc1_en", mem_en, 1'b1);
    @(negedge clk);
    chk1("abort_acc2_en", mem_en, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("abort_en_drop", mem_en, 1'b0);
    chk1("abort_busy_drop", busy, 1'b0);
    chk2("abort_ack", {if_ack, d_ack}, 2'b00);
    chk16("abort_if_rdata", if_rdata, 16'h0000);
    @(negedge clk);
    chk2("abort_no_ack", {if_ack, d_ack}, 2'b00);
    rst_n = 1'b1;
    exp_if_rd = 16'h0000;
    exp_d_rd  = 16'h0000;
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      chk1("replay_en", mem_en, 1'b1);
      chk16("replay_addr", mem_addr, 16'h0010);
      chk2("replay_ack_low", {if_ack, d_ack}, 2'b00);
    end
    @(negedge clk);
    chk2("replay_ack", {if_ack, d_ack}, 2'b10);
    exp_if_rd = 16'hABCD;
    chk16("replay_if_rdata", if_rdata, exp_if_rd);
    chk16("replay_d_rdata", d_rdata, exp_d_rd);
    if_req = 1'b0;
    @(negedge clk);

    // Randomized traffic against the transaction model.
    next_idle = 0; acc_valid = 1'b0; m_burst = 0;
    if_act = 1'b0; if_gnt = 1'b0; d_act = 1'b0; d_gnt = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      e_ack  = acc_valid && (cyc == ack_c);
      e_en   = acc_valid && (cyc > grant_c) && (cyc <= grant_c + W);
      e_busy = acc_valid;
      chk1("rnd_en", mem_en, e_en);
      chk1("rnd_busy", busy, e_busy);
      if (e_en) begin
        chk16("rnd_addr", mem_addr, own_addr);
        chk1("rnd_we", mem_we, own_d && own_we);
        if (own_d && own_we) chk16("rnd_wdata", mem_wdata, own_wdata);
      end
      chk2("rnd_ack", {if_ack, d_ack}, e_ack ? (own_d ? 2'b01 : 2'b10) : 2'b00);
      if (e_ack) begin
        if (own_d && own_we) ref_mem[int'(own_addr[9:0])] = own_wdata;
        else if (own_d) exp_d_rd = own_exp;
        else exp_if_rd = own_exp;
        if (own_d) begin d_act = 1'b0; d_gnt = 1'b0; end
        else begin if_act = 1'b0; if_gnt = 1'b0; end
        acc_valid = 1'b0;
      end
      chk16("rnd_if_rdata", if_rdata, exp_if_rd);
      chk16("rnd_d_rdata", d_rdata, exp_d_rd);

      if (!if_act) begin
        if ($urandom_range(0, 1) == 1) begin
          if_act = 1'b1; if_req = 1'b1; if_addr = rnd_addr();
        end else begin
          if_req = 1'b0; if_addr = 16'($urandom);
        end
      end else if (if_gnt) begin
        if_addr = 16'($urandom);
        if ($urandom_range(0, 3) == 0) if_req = 1'b0;
      end
      if (!d_act) begin
        if ($urandom_range(0, 1) == 1) begin
          d_act = 1'b1; d_req = 1'b1; d_addr = rnd_addr();
          d_we = 1'($urandom_range(0, 1)); d_wdata = 16'($urandom);
        end else begin
          d_req = 1'b0;
        end
      end else if (d_gnt) begin
        d_addr = 16'($urandom); d_wdata = 16'($urandom); d_we = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) d_req = 1'b0;
      end

      if (cyc == next_idle) begin
        if (if_req || d_req) begin
          gd = d_req && (!if_req || m_burst < MAXB);
          if (gd) begin
            own_d = 1'b1; own_we = d_we; own_addr = d_addr; own_wdata = d_wdata;
            if (m_burst < MAXB) m_burst++;
            d_gnt = 1'b1;
          end else begin
            own_d = 1'b0; own_we = 1'b0; own_addr = if_addr; own_wdata = 16'h0000;
            m_burst = 0;
            if_gnt = 1'b1;
          end
          own_exp   = ref_rd(own_addr);
          acc_valid = 1'b1;
          grant_c   = cyc;
          ack_c     = cyc + W + 1;
          next_idle = cyc + W + 2;
        end else begin
          next_idle = cyc + 1;
        end
      end
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    repeat (W + 3) @(negedge clk);

    // WAIT_CYCLES=1 instance with fetch held high: ACK every third cycle.
    if_req1 = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      chk1("w1_mem_en", mem_en1, (c % 3) == 1);
      chk1("w1_if_ack", if_ack1, (c % 3) == 2);
      if ((c % 3) == 2) chk16("w1_if_rdata", if_rdata1, 16'hC0DE);
    end
    if_req1 = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
